cnn_layer_ctrl: RTL and testbench
=================================

Name: cnn_layer_ctrl

Overview:
- Parametrised successor to the single-layer conv/pool/flatten sequencer.
- Internal counters replace the externally supplied index/reset pairs.
- Adds a channel loop (N_CH), runtime pool/flatten mode select, a synchronous ready start, a done pulse, and a return to idle so the block can be restarted.
- Drives the per-phase enable flags consumed by the address generators, MAC/ReLU datapath and output writers.

Parameters:
- CNT_WIDTH, 16, width of local_idx and row_idx; must hold the largest phase length L.
- CH_WIDTH, 4, width of ch_idx.
- N_CH, 2, number of output channels (≥1).
- IMG_W, 64, conv-layer output width (even).
- IMG_H, 64, conv-layer output height (even).
- CONV_PASSES, 64, conv passes per channel (≥1).
- IN_BUFFER_SIZE, 16, input buffer depth.
- OUT_BUFFER_SIZE, 3, output buffer depth.
- F_GEN_IN_ADDR..F_WRITE_FLAT_ENB, 0..7, flag bit positions, same order as before.
- F_CH_SWITCH, 8, flag bit position for the channel-advance pulse.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- ready  in  1  start request; sampled only in IDLE.
- pool_en  in  1  mode: run the pool phase; latched at start.
- flat_en  in  1  mode: run the flatten phase; latched at start; ignored when pool_en=0.
- busy  out  1  high in every state except IDLE and FINISH.
- done  out  1  one-cycle pulse in FINISH.
- flags  out  12  phase enables; unused bits are 0.
- local_idx  out  CNT_WIDTH  in-phase cycle counter.
- row_idx  out  CNT_WIDTH  conv pass index.
- ch_idx  out  CH_WIDTH  current channel.

Behaviour:
- Reset (asynchronous): state=IDLE; local_idx, row_idx, ch_idx and the latched modes = 0; flags=0; busy=0; done=0. Reset mid-operation aborts immediately, with no done pulse.
- Phase rule for a phase of length L: local_idx counts 0..L.
  - While local_idx<L: the phase flags are asserted and local_idx increments.
  - At local_idx==L (terminal cycle): flags=0, local_idx←0, take the exit transition.
  - Each phase therefore lasts L+1 cycles.
- Phase lengths:
  - READ_IN: L=3*IN_BUFFER_SIZE+2; flags READ_IN_ENB and GEN_IN_ADDR.
  - CONV_RELU: L=OUT_BUFFER_SIZE+1; flag CONV_RELU_ENB.
  - WRITE_CONV: L=2*OUT_BUFFER_SIZE+1; flag WRITE_CONV_ENB.
  - READ_CONV: L=IMG_W*IMG_H+2; flags READ_CONV_ENB and GEN_CONV_ADDR.
  - WRITE_POOL: L=IMG_W*IMG_H/4; flag WRITE_POOL_ENB.
  - WRITE_FLAT: L=N_CH*IMG_W*IMG_H/4; flag WRITE_FLAT_ENB.
- IDLE: busy=0. If ready=1, latch pool_en and flat_en&pool_en, then go to GEN_IN_ADDR. Start is synchronous, one cycle of latency.
- GEN_IN_ADDR: single cycle, flags[F_GEN_IN_ADDR]=1, then READ_IN.
- READ_IN → CONV_RELU → WRITE_CONV.
- WRITE_CONV terminal cycle:
  - If row_idx<CONV_PASSES-1: row_idx++, go to GEN_IN_ADDR.
  - Else, if ch_idx<N_CH-1: row_idx←0, ch_idx++, flags[F_CH_SWITCH]=1 this cycle, go to GEN_IN_ADDR.
  - Else: row_idx←0, ch_idx←0, go to GEN_CONV_ADDR if pool latched, otherwise FINISH.
- GEN_CONV_ADDR: single cycle, flags[F_GEN_CONV_ADDR]=1, then READ_CONV → WRITE_POOL.
- WRITE_POOL terminal cycle:
  - If ch_idx<N_CH-1: ch_idx++, F_CH_SWITCH pulse, go to GEN_CONV_ADDR.
  - Else: ch_idx←0, go to WRITE_FLAT if flat latched, otherwise FINISH.
- WRITE_FLAT terminal cycle: go to FINISH.
- FINISH: busy=0, done=1 for exactly one cycle, flags=0, then IDLE. ready during FINISH is ignored.
- ready and mode inputs are ignored while busy.
- Illegal state encoding: go to IDLE with outputs at reset values.
- All outputs are registered or decoded from state and counters only; there is no combinational path from ready to flags.

Test Plan:
- Params IN_BUFFER_SIZE=1, OUT_BUFFER_SIZE=1, CONV_PASSES=2, N_CH=2, IMG 4x4; pool_en=flat_en=1; ready pulse → busy high for exactly 115 cycles, done on cycle 116, then IDLE with busy=0.
- Same params, pool_en=0 → busy 56 cycles, done next cycle; flags[4..7] never asserted; flat_en is ignored.
- Same params, pool_en=1, flat_en=0 → busy 106 cycles; flags[7] never set; F_CH_SWITCH pulses exactly twice (after conv channel 0 and after pool channel 0).
- Per-phase check → READ_IN asserts flags 0 and 1 for exactly 5 cycles then one idle terminal cycle; WRITE_POOL flag 6 for 4 cycles; local_idx reads 0 on the first cycle of each phase.
- Assert reset during READ_CONV of channel 1 → all outputs are 0 asynchronously and no done pulse; a new ready then runs the full 115-cycle sequence.
- Hold ready=1 continuously → back-to-back runs separated by FINISH (1 cycle) and IDLE (1 cycle); ready toggling while busy changes nothing.

Source files
------------

// File: rtl/cnn_layer_ctrl.sv
// Conv/pool/flatten layer sequencer: walks every channel through conv passes, then optional
// pool and flatten phases, and drives the per-phase enable flags.
`timescale 1ns/1ps
module cnn_layer_ctrl #(
  parameter int CNT_WIDTH        = 16,
  parameter int CH_WIDTH         = 4,
  parameter int N_CH             = 2,
  parameter int IMG_W            = 64,
  parameter int IMG_H            = 64,
  parameter int CONV_PASSES      = 64,
  parameter int IN_BUFFER_SIZE   = 16,
  parameter int OUT_BUFFER_SIZE  = 3,
  parameter int F_GEN_IN_ADDR    = 0,
  parameter int F_READ_IN_ENB    = 1,
  parameter int F_CONV_RELU_ENB  = 2,
  parameter int F_WRITE_CONV_ENB = 3,
  parameter int F_GEN_CONV_ADDR  = 4,
  parameter int F_READ_CONV_ENB  = 5,
  parameter int F_WRITE_POOL_ENB = 6,
  parameter int F_WRITE_FLAT_ENB = 7,
  parameter int F_CH_SWITCH      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ready,
  input  logic                 pool_en,
  input  logic                 flat_en,
  output logic                 busy,
  output logic                 done,
  output logic [11:0]          flags,
  output logic [CNT_WIDTH-1:0] local_idx,
  output logic [CNT_WIDTH-1:0] row_idx,
  output logic [CH_WIDTH-1:0]  ch_idx
);

  localparam logic [CNT_WIDTH-1:0] L_READ_IN    = CNT_WIDTH'(3 * IN_BUFFER_SIZE + 2);
  localparam logic [CNT_WIDTH-1:0] L_CONV_RELU  = CNT_WIDTH'(OUT_BUFFER_SIZE + 1);
  localparam logic [CNT_WIDTH-1:0] L_WRITE_CONV = CNT_WIDTH'(2 * OUT_BUFFER_SIZE + 1);
  localparam logic [CNT_WIDTH-1:0] L_READ_CONV  = CNT_WIDTH'(IMG_W * IMG_H + 2);
  localparam logic [CNT_WIDTH-1:0] L_WRITE_POOL = CNT_WIDTH'(IMG_W * IMG_H / 4);
  localparam logic [CNT_WIDTH-1:0] L_WRITE_FLAT = CNT_WIDTH'(N_CH * IMG_W * IMG_H / 4);
  localparam logic [CNT_WIDTH-1:0] ROW_LAST     = CNT_WIDTH'(CONV_PASSES - 1);
  localparam logic [CH_WIDTH-1:0]  CH_LAST      = CH_WIDTH'(N_CH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE      = 1;
  localparam logic [CH_WIDTH-1:0]  CH_ONE       = 1;

  typedef enum logic [3:0] {
    S_IDLE, S_GEN_IN, S_READ_IN, S_CONV_RELU, S_WRITE_CONV,
    S_GEN_CONV, S_READ_CONV, S_WRITE_POOL, S_WRITE_FLAT, S_FINISH
  } state_t;

  state_t                 state_q;
  logic [CNT_WIDTH-1:0]   local_q;
  logic [CNT_WIDTH-1:0]   row_q;
  logic [CH_WIDTH-1:0]    ch_q;
  logic                   pool_q;
  logic                   flat_q;
  logic [CNT_WIDTH-1:0]   phase_len;
  logic                   last_cycle;
  logic                   more_rows;
  logic                   more_ch;

  always_comb begin
    phase_len = '0;
    case (state_q)
      S_READ_IN:    phase_len = L_READ_IN;
      S_CONV_RELU:  phase_len = L_CONV_RELU;
      S_WRITE_CONV: phase_len = L_WRITE_CONV;
      S_READ_CONV:  phase_len = L_READ_CONV;
      S_WRITE_POOL: phase_len = L_WRITE_POOL;
      S_WRITE_FLAT: phase_len = L_WRITE_FLAT;
      default:      phase_len = '0;
    endcase
  end

  assign last_cycle = (local_q == phase_len);
  assign more_rows  = (row_q < ROW_LAST);
  assign more_ch    = (ch_q < CH_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      local_q <= '0;
      row_q   <= '0;
      ch_q    <= '0;
      pool_q  <= 1'b0;
      flat_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ready) begin
            pool_q  <= pool_en;
            flat_q  <= flat_en & pool_en;
            state_q <= S_GEN_IN;
          end
        end
        S_GEN_IN:   state_q <= S_READ_IN;
        S_GEN_CONV: state_q <= S_READ_CONV;
        S_FINISH:   state_q <= S_IDLE;
        S_READ_IN, S_CONV_RELU, S_WRITE_CONV, S_READ_CONV, S_WRITE_POOL, S_WRITE_FLAT: begin
          if (!last_cycle) begin
            local_q <= local_q + CNT_ONE;
          end else begin
            local_q <= '0;
            case (state_q)
              S_READ_IN:   state_q <= S_CONV_RELU;
              S_CONV_RELU: state_q <= S_WRITE_CONV;
              S_READ_CONV: state_q <= S_WRITE_POOL;
              S_WRITE_FLAT: state_q <= S_FINISH;
              S_WRITE_CONV: begin
                if (more_rows) begin
                  row_q   <= row_q + CNT_ONE;
                  state_q <= S_GEN_IN;
                end else if (more_ch) begin
                  row_q   <= '0;
                  ch_q    <= ch_q + CH_ONE;
                  state_q <= S_GEN_IN;
                end else begin
                  row_q   <= '0;
                  ch_q    <= '0;
                  state_q <= pool_q ? S_GEN_CONV : S_FINISH;
                end
              end
              default: begin
                // WRITE_POOL: next channel, or leave the pool loop
                if (more_ch) begin
                  ch_q    <= ch_q + CH_ONE;
                  state_q <= S_GEN_CONV;
                end else begin
                  ch_q    <= '0;
                  state_q <= flat_q ? S_WRITE_FLAT : S_FINISH;
                end
              end
            endcase
          end
        end
        default: begin
          state_q <= S_IDLE;
          local_q <= '0;
          row_q   <= '0;
          ch_q    <= '0;
          pool_q  <= 1'b0;
          flat_q  <= 1'b0;
        end
      endcase
    end
  end

  // Flags decode from registered state and counters only, so ready never reaches them combinationally.
  always_comb begin
    flags = '0;
    case (state_q)
      S_GEN_IN:   flags[F_GEN_IN_ADDR] = 1'b1;
      S_READ_IN: begin
        flags[F_READ_IN_ENB] = !last_cycle;
        flags[F_GEN_IN_ADDR] = !last_cycle;
      end
      S_CONV_RELU: flags[F_CONV_RELU_ENB] = !last_cycle;
      S_WRITE_CONV: begin
        flags[F_WRITE_CONV_ENB] = !last_cycle;
        flags[F_CH_SWITCH]      = last_cycle && !more_rows && more_ch;
      end
      S_GEN_CONV: flags[F_GEN_CONV_ADDR] = 1'b1;
      S_READ_CONV: begin
        flags[F_READ_CONV_ENB] = !last_cycle;
        flags[F_GEN_CONV_ADDR] = !last_cycle;
      end
      S_WRITE_POOL: begin
        flags[F_WRITE_POOL_ENB] = !last_cycle;
        flags[F_CH_SWITCH]      = last_cycle && more_ch;
      end
      S_WRITE_FLAT: flags[F_WRITE_FLAT_ENB] = !last_cycle;
      default: flags = '0;
    endcase
  end

  assign busy      = (state_q >= S_GEN_IN) && (state_q <= S_WRITE_FLAT);
  assign done      = (state_q == S_FINISH);
  assign local_idx = local_q;
  assign row_idx   = row_q;
  assign ch_idx    = ch_q;

endmodule

// File: tb/tb_cnn_layer_ctrl.sv
// Directed bench for cnn_layer_ctrl with a small 4x4, 2-channel, 2-pass configuration.
`timescale 1ns/1ps
module tb_cnn_layer_ctrl;

  logic        clk = 1'b0;
  logic        reset, ready, pool_en, flat_en;
  logic        busy, done;
  logic [11:0] flags;
  logic [15:0] local_idx, row_idx;
  logic [3:0]  ch_idx;

  int checks = 0;
  int errors = 0;

  logic [11:0] tr_flags [0:299];
  logic [15:0] tr_loc   [0:299];
  logic [15:0] tr_row   [0:299];
  logic [3:0]  tr_ch    [0:299];
  int          busy_cnt, sw_cnt, n;
  logic [11:0] flag_or;

  cnn_layer_ctrl #(
    .CNT_WIDTH(16), .CH_WIDTH(4), .N_CH(2), .IMG_W(4), .IMG_H(4),
    .CONV_PASSES(2), .IN_BUFFER_SIZE(1), .OUT_BUFFER_SIZE(1)
  ) dut (
    .clk(clk), .reset(reset), .ready(ready), .pool_en(pool_en), .flat_en(flat_en),
    .busy(busy), .done(done), .flags(flags),
    .local_idx(local_idx), .row_idx(row_idx), .ch_idx(ch_idx)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_done"}, {31'd0, done}, 0);
    chk({tag, "_flags"}, {20'd0, flags}, 0);
    chk({tag, "_local"}, {16'd0, local_idx}, 0);
    chk({tag, "_row"}, {16'd0, row_idx}, 0);
    chk({tag, "_ch"}, {28'd0, ch_idx}, 0);
  endtask

  // Starts from IDLE, records one trace entry per busy cycle, checks the FINISH/IDLE tail.
  task automatic run(input logic p, input logic f, input bit wiggle);
    pool_en = p; flat_en = f; ready = 1'b1;
    tick;
    ready = 1'b0;
    busy_cnt = 0; sw_cnt = 0; flag_or = '0;
    while (busy === 1'b1 && busy_cnt < 300) begin
      tr_flags[busy_cnt] = flags;
      tr_loc[busy_cnt]   = local_idx;
      tr_row[busy_cnt]   = row_idx;
      tr_ch[busy_cnt]    = ch_idx;
      flag_or |= flags;
      if (flags[8]) sw_cnt++;
      if (wiggle) begin
        ready   = 1'($urandom_range(0, 1));
        pool_en = 1'($urandom_range(0, 1));
        flat_en = 1'($urandom_range(0, 1));
      end
      busy_cnt++;
      tick;
    end
    ready = 1'b0;
    chk("finish_done", {31'd0, done}, 1);
    chk("finish_flags", {20'd0, flags}, 0);
    tick;
    chk("idle_done", {31'd0, done}, 0);
    chk("idle_busy", {31'd0, busy}, 0);
    $display("run pool=%0d flat=%0d wiggle=%0d busy_cycles=%0d ch_switch=%0d flag_or=%03h",
             p, f, wiggle, busy_cnt, sw_cnt, flag_or);
  endtask

  initial begin
    reset = 1'b1; ready = 1'b0; pool_en = 1'b0; flat_en = 1'b0;
    #12;
    check_all_zero("reset");
    tick;
    reset = 1'b0;
    tick;
    check_all_zero("post_reset");

    // Full run: conv + pool + flatten
    run(1'b1, 1'b1, 1'b0);
    chk("full_busy", busy_cnt, 115);
    chk("full_sw", sw_cnt, 2);
    chk("gen_in_flags", {20'd0, tr_flags[0]}, 32'h001);
    chk("read_in_first", {20'd0, tr_flags[1]}, 32'h003);
    chk("read_in_loc0", {16'd0, tr_loc[1]}, 0);
    chk("read_in_last_en", {20'd0, tr_flags[5]}, 32'h003);
    chk("read_in_loc4", {16'd0, tr_loc[5]}, 4);
    chk("read_in_term", {20'd0, tr_flags[6]}, 0);
    chk("read_in_term_loc", {16'd0, tr_loc[6]}, 5);
    chk("conv_relu_first", {20'd0, tr_flags[7]}, 32'h004);
    chk("conv_relu_loc0", {16'd0, tr_loc[7]}, 0);
    chk("write_conv_en", {20'd0, tr_flags[10]}, 32'h008);
    chk("write_conv_term", {20'd0, tr_flags[13]}, 0);
    chk("row1", {16'd0, tr_row[14]}, 1);
    chk("conv_ch_switch", {20'd0, tr_flags[27]}, 32'h100);
    chk("conv_ch1", {28'd0, tr_ch[28]}, 1);
    chk("conv_ch1_row0", {16'd0, tr_row[28]}, 0);
    chk("last_write_conv_term", {20'd0, tr_flags[55]}, 0);
    chk("gen_conv_flags", {20'd0, tr_flags[56]}, 32'h010);
    chk("gen_conv_ch0", {28'd0, tr_ch[56]}, 0);
    chk("read_conv_flags", {20'd0, tr_flags[57]}, 32'h030);
    chk("read_conv_term", {20'd0, tr_flags[75]}, 0);
    chk("write_pool_first", {20'd0, tr_flags[76]}, 32'h040);
    chk("write_pool_loc0", {16'd0, tr_loc[76]}, 0);
    chk("write_pool_last_en", {20'd0, tr_flags[79]}, 32'h040);
    chk("pool_ch_switch", {20'd0, tr_flags[80]}, 32'h100);
    chk("pool_ch1", {28'd0, tr_ch[81]}, 1);
    chk("pool_last_term", {20'd0, tr_flags[105]}, 0);
    chk("write_flat_first", {20'd0, tr_flags[106]}, 32'h080);
    chk("write_flat_loc0", {16'd0, tr_loc[106]}, 0);
    chk("write_flat_last_en", {20'd0, tr_flags[113]}, 32'h080);
    chk("write_flat_term", {20'd0, tr_flags[114]}, 0);
    n = 0;
    for (int i = 0; i < 115; i++) if (tr_flags[i][6]) n++;
    chk("pool_flag_cycles", n, 8);
    n = 0;
    for (int i = 0; i < 115; i++) if (tr_flags[i][1]) n++;
    chk("read_in_cycles", n, 20);

    // Conv only: flat_en must be ignored without pool
    run(1'b0, 1'b1, 1'b0);
    chk("conv_only_busy", busy_cnt, 56);
    chk("conv_only_pool_flags", {28'd0, flag_or[7:4]}, 0);
    chk("conv_only_sw", sw_cnt, 1);

    // Conv + pool, no flatten
    run(1'b1, 1'b0, 1'b0);
    chk("pool_only_busy", busy_cnt, 106);
    chk("pool_only_flat_flag", {31'd0, flag_or[7]}, 0);
    chk("pool_only_sw", sw_cnt, 2);

    // Inputs toggling while busy must not disturb a latched run
    run(1'b1, 1'b1, 1'b1);
    chk("wiggle_full_busy", busy_cnt, 115);
    run(1'b0, 1'b0, 1'b1);
    chk("wiggle_conv_busy", busy_cnt, 56);

    // Asynchronous reset during READ_CONV of channel 1
    pool_en = 1'b1; flat_en = 1'b1; ready = 1'b1;
    tick;
    ready = 1'b0;
    repeat (90) tick;
    chk("pre_abort_flags", {20'd0, flags}, 32'h030);
    chk("pre_abort_ch", {28'd0, ch_idx}, 1);
    #3 reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    tick;
    chk("abort_no_done", {31'd0, done}, 0);
    reset = 1'b0;
    tick;
    chk("abort_idle", {31'd0, busy}, 0);
    run(1'b1, 1'b1, 1'b0);
    chk("restart_busy", busy_cnt, 115);

    // Continuous ready: FINISH then IDLE, then the next run starts
    pool_en = 1'b1; flat_en = 1'b1; ready = 1'b1;
    tick;
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      n++;
      tick;
    end
    chk("hold_busy", n, 115);
    chk("hold_finish_done", {31'd0, done}, 1);
    tick;
    chk("hold_idle_busy", {31'd0, busy}, 0);
    chk("hold_idle_done", {31'd0, done}, 0);
    tick;
    chk("hold_restart_busy", {31'd0, busy}, 1);
    chk("hold_restart_flags", {20'd0, flags}, 32'h001);
    ready = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      n++;
      tick;
    end
    chk("hold_second_busy", n, 115);
    $display("run hold_ready second_busy_cycles=%0d", n);
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
